bram_initiator: RTL and testbench

- Requester-side master for the single-port bram interface (valid/instr/addr/wdata/wstrb → rdata/ready).
- Accepts one-cycle request pulses from the instruction-fetch port (imem) and the load/store port (dmem), holds each in a single-entry slot, and round-robin arbitrates them onto the bram interface.
- Issues a one-cycle bram_valid per access, waits for bram_ready, routes the response back, and enforces a response timeout.

---
 rtl/bram_initiator_pkg.sv | 38 +++
 rtl/bram_req_slot.sv | 51 +++++
 rtl/bram_initiator.sv | 190 +++++++++++++++++++
 tb/tb_bram_initiator.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_initiator_pkg.sv
// Shared types and defaults for the bram requester-side master.
package bram_initiator_pkg;

  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned DefaultCntW    = 7;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  typedef enum logic {
    PortImem = 1'b0,
    PortDmem = 1'b1
  } port_e;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_slot_t;

  // Round-robin pick: a lone pending port wins; a tie goes to the port not granted last.
  function automatic port_e arbitrate(input logic imem_pend, input logic dmem_pend,
                                      input port_e last);
    if (imem_pend && dmem_pend) begin
      return (last == PortImem) ? PortDmem : PortImem;
    end else if (dmem_pend) begin
      return PortDmem;
    end else begin
      return PortImem;
    end
  endfunction

endpackage

// File: rtl/bram_req_slot.sv
// Single-entry request holding register; flags requests that arrive while occupied.
module bram_req_slot
  import bram_initiator_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        instr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        clear_i,
  output req_slot_t   slot_o,
  output logic        overrun_o
);

  req_slot_t slot_d, slot_q;

  // Capture into an empty slot; a request hitting an occupied slot is dropped.
  always_comb begin
    slot_d    = slot_q;
    overrun_o = 1'b0;
    if (clear_i) begin
      slot_d.valid = 1'b0;
    end
    if (req_i) begin
      if (slot_q.valid) begin
        // Still occupied even if it is being answered this cycle.
        overrun_o = 1'b1;
      end else begin
        slot_d.valid = 1'b1;
        slot_d.instr = instr_i;
        slot_d.addr  = addr_i;
        slot_d.wdata = wdata_i;
        slot_d.wstrb = wstrb_i;
      end
    end
  end

  // Slot register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/bram_initiator.sv
// Arbitrates fetch and load/store requests onto a single-port bram with response timeout.
module bram_initiator
  import bram_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e            state_d, state_q;
  port_e             grant_d, grant_q;
  port_e             last_d, last_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              bram_valid_d, bram_valid_q;
  logic              bram_instr_d, bram_instr_q;
  logic [31:0]       bram_addr_d, bram_addr_q;
  logic [31:0]       bram_wdata_d, bram_wdata_q;
  logic [3:0]        bram_wstrb_d, bram_wstrb_q;
  logic              err_timeout_d, err_timeout_q;
  logic              err_overrun_d, err_overrun_q;

  req_slot_t         imem_slot, dmem_slot, sel;
  logic              imem_ovr, dmem_ovr, imem_clr, dmem_clr;
  logic              pend_i, pend_d, arb, resp;
  logic [31:0]       resp_data;

  bram_req_slot u_imem_slot (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (imem_valid),
    .instr_i   (1'b1),
    .addr_i    (imem_addr),
    .wdata_i   (32'h0),
    .wstrb_i   (4'h0),
    .clear_i   (imem_clr),
    .slot_o    (imem_slot),
    .overrun_o (imem_ovr)
  );

  bram_req_slot u_dmem_slot (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (dmem_valid),
    .instr_i   (1'b0),
    .addr_i    (dmem_addr),
    .wdata_i   (dmem_wdata),
    .wstrb_i   (dmem_wstrb),
    .clear_i   (dmem_clr),
    .slot_o    (dmem_slot),
    .overrun_o (dmem_ovr)
  );

  // Next-state, grant, bram register loads and response routing.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    bram_valid_d  = 1'b0;
    bram_instr_d  = bram_instr_q;
    bram_addr_d   = bram_addr_q;
    bram_wdata_d  = bram_wdata_q;
    bram_wstrb_d  = bram_wstrb_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q | imem_ovr | dmem_ovr;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    dmem_ready    = 1'b0;
    dmem_rdata    = 32'h0;
    imem_clr      = 1'b0;
    dmem_clr      = 1'b0;
    pend_i        = imem_slot.valid;
    pend_d        = dmem_slot.valid;
    arb           = 1'b0;
    resp          = 1'b0;
    resp_data     = 32'h0;
    sel           = imem_slot;

    unique case (state_q)
      StIdle: begin
        arb = pend_i | pend_d;
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (bram_ready) begin
          resp      = 1'b1;
          resp_data = bram_rdata;
        end else if (cnt_q == CntLast) begin
          // Forced error response; data stays zero.
          resp          = 1'b1;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (resp) begin
          if (grant_q == PortImem) begin
            imem_ready = 1'b1;
            imem_rdata = resp_data;
            imem_clr   = 1'b1;
            pend_i     = 1'b0;
          end else begin
            dmem_ready = 1'b1;
            dmem_rdata = resp_data;
            dmem_clr   = 1'b1;
            pend_d     = 1'b0;
          end
          state_d = StIdle;
          arb     = pend_i | pend_d;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arb) begin
      grant_d      = arbitrate(pend_i, pend_d, last_q);
      last_d       = grant_d;
      sel          = (grant_d == PortImem) ? imem_slot : dmem_slot;
      state_d      = StIssue;
      bram_valid_d = 1'b1;
      bram_instr_d = sel.instr;
      bram_addr_d  = sel.addr;
      bram_wdata_d = sel.wdata;
      bram_wstrb_d = sel.wstrb;
    end
  end

  // State and registered bram outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= PortImem;
      last_q        <= PortImem;
      cnt_q         <= '0;
      bram_valid_q  <= 1'b0;
      bram_instr_q  <= 1'b0;
      bram_addr_q   <= 32'h0;
      bram_wdata_q  <= 32'h0;
      bram_wstrb_q  <= 4'h0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      bram_valid_q  <= bram_valid_d;
      bram_instr_q  <= bram_instr_d;
      bram_addr_q   <= bram_addr_d;
      bram_wdata_q  <= bram_wdata_d;
      bram_wstrb_q  <= bram_wstrb_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bram_valid  = bram_valid_q;
  assign bram_instr  = bram_instr_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wdata  = bram_wdata_q;
  assign bram_wstrb  = bram_wstrb_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_bram_initiator.sv
// Bench for bram_initiator: memory responder, transaction-timing model, directed and random traffic.
module tb_bram_initiator;

  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr = 32'h0;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        bram_valid;
  logic        bram_instr;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_wstrb;
  logic [31:0] bram_rdata;
  logic        bram_ready;
  logic        err_timeout;
  logic        err_overrun;

  bram_initiator #(
    .TIMEOUT (Timeout),
    .CNT_W   (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_valid  (imem_valid),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dmem_valid  (dmem_valid),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .bram_valid  (bram_valid),
    .bram_instr  (bram_instr),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .bram_wstrb  (bram_wstrb),
    .bram_rdata  (bram_rdata),
    .bram_ready  (bram_ready),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return (i == 'h40) ? 32'h0000_0013 : {k, 8'h5a, ~k, 8'hc3};
  endfunction

  // Memory responder: answers one cycle after bram_valid unless muted.
  logic [31:0] rmem [256];
  bit          init_done = 1'b0;
  logic        resp_q = 1'b0;
  logic [31:0] resp_data_q = 32'h0;
  logic [31:0] garbage_q = 32'h0;
  logic        mute = 1'b0;
  logic        stray = 1'b0;

  always @(posedge clk) begin
    garbage_q <= $urandom;
    resp_q    <= bram_valid && !mute;
    if (!init_done) begin
      for (int i = 0; i < 256; i++) rmem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (bram_valid) begin
      resp_data_q          <= rmem[bram_addr[9:2]];
      rmem[bram_addr[9:2]] <= merge(rmem[bram_addr[9:2]], bram_wdata, bram_wstrb);
    end
  end

  assign bram_ready = resp_q | stray;
  assign bram_rdata = bram_ready ? resp_data_q : garbage_q;

  // Observations used by the directed checks.
  int          obs_bv_cyc [2] = '{-100, -100};
  int          obs_rdy_cyc [2] = '{-100, -100};
  logic [31:0] obs_rdy_data [2] = '{32'h0, 32'h0};
  int          obs_last_cyc = -100;
  logic        obs_last_instr = 1'b0;
  logic [3:0]  obs_last_wstrb = 4'h0;
  logic [31:0] obs_last_addr = 32'h0;
  int          bv_count = 0;
  int          rdy_count = 0;

  // Reference model: issue at max(request+2, previous response+1), response one cycle after
  // issue (or Timeout cycles when the responder is mute); ties go to the port not last granted.
  initial begin
    logic [31:0] mmem [256];
    bit          pend [2];
    logic [31:0] m_addr [2], m_wdata [2];
    logic [3:0]  m_wstrb [2];
    int          m_cyc [2];
    bit          occ [2];
    bit          inflight, fl_to, exp_to, exp_ov, to_next, c0, c1, e_bv;
    int          fl_port, resp_cyc, free_at, last_g, w;
    logic [31:0] fl_data;
    logic        e_rdy [2];
    logic [31:0] e_data [2];
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
    pend = '{0, 0};
    inflight = 0; fl_to = 0; exp_to = 0; exp_ov = 0; fl_port = 0; resp_cyc = 0;
    free_at = 0; last_g = 0; fl_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = '{0, 0};
        inflight = 0; free_at = 0; last_g = 0; exp_to = 0; exp_ov = 0;
        chk("reset_bram_valid", {31'h0, bram_valid}, 32'h0);
        chk("reset_readies", {30'h0, imem_ready, dmem_ready}, 32'h0);
        chk("reset_rdata", imem_rdata | dmem_rdata, 32'h0);
        chk("reset_err_flags", {30'h0, err_timeout, err_overrun}, 32'h0);
      end else begin
        occ[0] = pend[0];
        occ[1] = pend[1];
        e_rdy  = '{1'b0, 1'b0};
        e_data = '{32'h0, 32'h0};
        to_next = 0;
        if (inflight && resp_cyc == cyc) begin
          e_rdy[fl_port]  = 1'b1;
          e_data[fl_port] = fl_to ? 32'h0 : fl_data;
          pend[fl_port]   = 0;
          inflight        = 0;
          free_at         = cyc + 1;
          to_next         = fl_to;
        end
        e_bv = 0;
        if (!inflight && cyc >= free_at) begin
          c0 = pend[0] && (m_cyc[0] <= cyc - 2);
          c1 = pend[1] && (m_cyc[1] <= cyc - 2);
          if (c0 || c1) begin
            w        = (c0 && c1) ? (1 - last_g) : (c1 ? 1 : 0);
            e_bv     = 1;
            last_g   = w;
            inflight = 1;
            fl_port  = w;
            fl_to    = mute;
            resp_cyc = cyc + (mute ? Timeout : 1);
            fl_data  = mmem[m_addr[w][9:2]];
            mmem[m_addr[w][9:2]] = merge(fl_data, m_wdata[w], m_wstrb[w]);
          end
        end
        chk("bram_valid", {31'h0, bram_valid}, {31'h0, e_bv});
        if (e_bv) begin
          chk("bram_instr", {31'h0, bram_instr}, (fl_port == 0) ? 32'h1 : 32'h0);
          chk("bram_addr", bram_addr, m_addr[fl_port]);
          chk("bram_wdata", bram_wdata, m_wdata[fl_port]);
          chk("bram_wstrb", {28'h0, bram_wstrb}, {28'h0, m_wstrb[fl_port]});
        end
        chk("imem_ready", {31'h0, imem_ready}, {31'h0, e_rdy[0]});
        chk("imem_rdata", imem_rdata, e_data[0]);
        chk("dmem_ready", {31'h0, dmem_ready}, {31'h0, e_rdy[1]});
        chk("dmem_rdata", dmem_rdata, e_data[1]);
        chk("err_timeout", {31'h0, err_timeout}, {31'h0, exp_to});
        chk("err_overrun", {31'h0, err_overrun}, {31'h0, exp_ov});
        if (to_next) exp_to = 1;
        if (imem_valid) begin
          if (occ[0]) exp_ov = 1;
          else begin
            pend[0] = 1; m_cyc[0] = cyc; m_addr[0] = imem_addr;
            m_wdata[0] = 32'h0; m_wstrb[0] = 4'h0;
          end
        end
        if (dmem_valid) begin
          if (occ[1]) exp_ov = 1;
          else begin
            pend[1] = 1; m_cyc[1] = cyc; m_addr[1] = dmem_addr;
            m_wdata[1] = dmem_wdata; m_wstrb[1] = dmem_wstrb;
          end
        end
      end
      if (bram_valid) begin
        obs_bv_cyc[bram_instr ? 0 : 1] = cyc;
        obs_last_cyc   = cyc;
        obs_last_instr = bram_instr;
        obs_last_wstrb = bram_wstrb;
        obs_last_addr  = bram_addr;
        bv_count++;
      end
      if (imem_ready) begin
        obs_rdy_cyc[0] = cyc; obs_rdy_data[0] = imem_rdata; rdy_count++;
      end
      if (dmem_ready) begin
        obs_rdy_cyc[1] = cyc; obs_rdy_data[1] = dmem_rdata; rdy_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    stray      = 1'b0;
  endtask

  task automatic req_imem(input logic [31:0] a);
    imem_valid = 1'b1;
    imem_addr  = a;
  endtask

  task automatic req_dmem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    dmem_valid = 1'b1;
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_wstrb = ws;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    repeat (3) step();
    chk("init_bram_valid", {31'h0, bram_valid}, 32'h0);
    chk("init_err_flags", {30'h0, err_timeout, err_overrun}, 32'h0);
    rst = 1'b0;

    // Single fetch.
    step(); req_imem(32'h100); c = cyc;
    repeat (6) step();
    chk("fetch_bv_latency", obs_last_cyc - c, 2);
    chk("fetch_bram_instr", {31'h0, obs_last_instr}, 32'h1);
    chk("fetch_bram_wstrb", {28'h0, obs_last_wstrb}, 32'h0);
    chk("fetch_bram_addr", obs_last_addr, 32'h100);
    chk("fetch_ready_latency", obs_rdy_cyc[0] - c, 3);
    chk("fetch_rdata", obs_rdy_data[0], 32'h13);

    // Store, load back, byte store, load back.
    step(); req_dmem(32'h200, 32'hDEADBEEF, 4'hF);
    repeat (5) step();
    req_dmem(32'h200, 32'h0, 4'h0); c = cyc;
    repeat (5) step();
    chk("load_latency", obs_rdy_cyc[1] - c, 3);
    chk("load_rdata", obs_rdy_data[1], 32'hDEADBEEF);
    req_dmem(32'h200, 32'h0000AA00, 4'h2);
    repeat (5) step();
    req_dmem(32'h200, 32'h0, 4'h0);
    repeat (5) step();
    chk("byte_store_rdata", obs_rdy_data[1], 32'hDEADAAEF);

    // Tie right after reset: dmem first.
    do_reset();
    req_imem(32'h100); req_dmem(32'h10, 32'h0, 4'h0); c = cyc;
    repeat (8) step();
    chk("tie1_dmem_bv", obs_bv_cyc[1] - c, 2);
    chk("tie1_imem_bv", obs_bv_cyc[0] - c, 4);
    req_dmem(32'h14, 32'h0, 4'h0);
    repeat (5) step();
    req_imem(32'h104); req_dmem(32'h18, 32'h0, 4'h0); c = cyc;
    repeat (8) step();
    chk("tie2_imem_bv", obs_bv_cyc[0] - c, 2);
    chk("tie2_dmem_bv", obs_bv_cyc[1] - c, 4);

    // Overrun: two consecutive dmem requests.
    req_dmem(32'h40, 32'h0, 4'h0); n = bv_count;
    step(); req_dmem(32'h44, 32'h0, 4'h0);
    repeat (6) step();
    chk("overrun_one_access", bv_count - n, 1);
    chk("overrun_flag", {31'h0, err_overrun}, 32'h1);
    repeat (5) step();
    chk("overrun_sticky", {31'h0, err_overrun}, 32'h1);

    // Timeout with a pending fetch behind it.
    mute = 1'b1;
    step(); req_dmem(32'h80, 32'h0, 4'h0); c = cyc;
    step(); step(); step(); req_imem(32'h100);
    step(); step(); mute = 1'b0;
    repeat (16) step();
    chk("timeout_resp_cycle", obs_rdy_cyc[1] - c, 10);
    chk("timeout_rdata", obs_rdy_data[1], 32'h0);
    chk("timeout_flag", {31'h0, err_timeout}, 32'h1);
    chk("after_timeout_fetch_cycle", obs_rdy_cyc[0] - c, 12);
    chk("after_timeout_fetch_rdata", obs_rdy_data[0], 32'h13);

    // Reset in the middle of a wait.
    mute = 1'b1;
    step(); req_dmem(32'h84, 32'h0, 4'h0);
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midreset_bram_valid", {31'h0, bram_valid}, 32'h0);
    chk("midreset_readies", {30'h0, imem_ready, dmem_ready}, 32'h0);
    chk("midreset_err_timeout", {31'h0, err_timeout}, 32'h0);
    chk("midreset_err_overrun", {31'h0, err_overrun}, 32'h0);
    step(); step();
    rst = 1'b0; mute = 1'b0;
    n = rdy_count;
    step(); stray = 1'b1;
    step(); step();
    chk("stray_ready_ignored", rdy_count - n, 0);
    req_imem(32'h100); c = cyc;
    repeat (6) step();
    chk("post_reset_latency", obs_rdy_cyc[0] - c, 3);
    chk("post_reset_rdata", obs_rdy_data[0], 32'h13);

    // Random traffic.
    repeat (400) begin
      step();
      if ($urandom_range(0, 3) == 0) req_imem({22'h0, 8'($urandom_range(0, 255)), 2'b00});
      if ($urandom_range(0, 3) == 0) begin
        req_dmem({22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      end
    end
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
